// File: rtl/dmem_arbiter_if.sv
// Requester-side bus of the data-memory arbiter: two request ports (A = core, B = loader)
// plus the shared tagged read-return path.
interface dmem_arbiter_if #(
    parameter int DATA_W = 12,
    parameter int ADDR_W = 12
) ();
    logic              a_req;
    logic              a_we;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_wdata;
    logic              a_gnt;
    logic              a_rvalid;

    logic              b_req;
    logic              b_we;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_wdata;
    logic              b_gnt;
    logic              b_rvalid;

    logic [DATA_W-1:0] rdata;

    modport master (
        output a_req, a_we, a_addr, a_wdata,
        output b_req, b_we, b_addr, b_wdata,
        input  a_gnt, a_rvalid, b_gnt, b_rvalid, rdata
    );

    modport slave (
        input  a_req, a_we, a_addr, a_wdata,
        input  b_req, b_we, b_addr, b_wdata,
        output a_gnt, a_rvalid, b_gnt, b_rvalid, rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter/sequencer for the single-port data memory.
// Define DMEM_ARB_RR_EN for round-robin with MAX_BURST fairness; otherwise fixed priority (A first).
module dmem_arbiter #(
    parameter int DATA_W    = 12,
    parameter int ADDR_W    = 12,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    dmem_arbiter_if.slave     bus,
    output logic              mem_write_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_datain,
    input  logic [DATA_W-1:0] mem_dataout
);

    logic              last_win;   // 0 = A, 1 = B
    logic [1:0]        rd_pend;    // {valid, owner}
    logic [ADDR_W-1:0] addr_q;

    logic              win_a;
    logic              win_b;
    logic              any_gnt;
    logic              win_we;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_wdata;

`ifdef DMEM_ARB_RR_EN
    localparam int              CNT_W     = 4;
    localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_BURST);

    logic [CNT_W-1:0] burst_cnt;
    logic             pick_b;

    always_comb begin
        win_a  = 1'b0;
        win_b  = 1'b0;
        // Under contention the previous winner keeps the port until its burst is used up.
        pick_b = (burst_cnt < BURST_MAX) ? last_win : ~last_win;
        if (rst_n) begin
            if (bus.a_req && bus.b_req) begin
                win_a = ~pick_b;
                win_b = pick_b;
            end else begin
                win_a = bus.a_req;
                win_b = bus.b_req;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            burst_cnt <= BURST_MAX;
        end else if (any_gnt) begin
            if (win_b != last_win) begin
                burst_cnt <= CNT_W'(1);
            end else if (burst_cnt < BURST_MAX) begin
                burst_cnt <= burst_cnt + CNT_W'(1);
            end
        end
    end
`else
    always_comb begin
        win_a = 1'b0;
        win_b = 1'b0;
        if (rst_n) begin
            win_a = bus.a_req;
            win_b = bus.b_req & ~bus.a_req;
        end
    end
`endif

    assign any_gnt   = win_a | win_b;
    assign win_we    = win_b ? bus.b_we    : bus.a_we;
    assign win_addr  = win_b ? bus.b_addr  : bus.a_addr;
    assign win_wdata = win_b ? bus.b_wdata : bus.a_wdata;

    assign bus.a_gnt = win_a;
    assign bus.b_gnt = win_b;

    // With no grant the address register keeps the memory doing a harmless read.
    assign mem_write_en = any_gnt & win_we;
    assign mem_addr     = any_gnt ? win_addr  : addr_q;
    assign mem_datain   = any_gnt ? win_wdata : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_win <= 1'b1;
            addr_q   <= '0;
            rd_pend  <= 2'b00;
        end else begin
            // Owner bit follows the most recent winner; only the valid bit qualifies it.
            rd_pend <= {any_gnt & ~win_we, any_gnt ? win_b : last_win};
            if (any_gnt) begin
                last_win <= win_b;
                addr_q   <= win_addr;
            end
        end
    end

    // Read-return stage: memory output is already registered, so it is steered straight through.
    assign bus.a_rvalid = rd_pend[1] & ~rd_pend[0];
    assign bus.b_rvalid = rd_pend[1] &  rd_pend[0];
    assign bus.rdata    = rd_pend[1] ? mem_dataout : '0;

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester arbiter and sequencer for the single-port 4096×12 data memory. It shares the memory's one `write_en`/`addr`/`datain`/`dataout` port between the processor core (port A) and the matrix loader/dumper (port B). It issues at most one memory access per cycle and returns read data to the requester that issued the read, with a tag. It sits between the bus/core, the loader and the data memory.

## Interface
- `DATA_W`, 12: width of write data and read data on all ports.
- `ADDR_W`, 12: memory address width.
- `MAX_BURST`, 4: maximum consecutive grants to one requester while the other is waiting; used only in round-robin mode; legal range 1..15.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `a_req`, `b_req`  in  1  access request, held until granted.
- `a_we`, `b_we`  in  1  1 = write, 0 = read; valid while req is high.
- `a_addr`, `b_addr`  in  ADDR_W  access address.
- `a_wdata`, `b_wdata`  in  DATA_W  write data.
- `a_gnt`, `b_gnt`  out  1  combinational grant; the access is issued this cycle.
- `a_rvalid`, `b_rvalid`  out  1  registered; read data valid this cycle.
- `rdata`  out  DATA_W  read data, shared by both requesters and qualified by the rvalid signals.
- `mem_write_en`  out  1  to the data memory `write_en`.
- `mem_addr`  out  ADDR_W  to the data memory `addr`.
- `mem_datain`  out  DATA_W  to the data memory `datain`; zero-extended if the memory port is wider.
- `mem_dataout`  in  DATA_W  from the data memory `dataout`; registered there, one cycle after the address.

## Operation
- **Arbitration:** combinational from `a_req`, `b_req` and the registered state `last_win` (0=A, 1=B) and `burst_cnt`.
  - At most one grant per cycle.
  - A grant is never asserted without the matching req.
- **Granted cycle:**
  - `mem_addr` is driven from the winner's addr.
  - `mem_write_en` is set to the winner's we.
  - `mem_datain` is driven from the winner's wdata.
- **No grant:** `mem_write_en`=0 and `mem_addr` holds the last granted address in a register. The memory therefore performs a harmless read.
- **Read tracking:** the pipeline register `rd_pend[1:0]` = {valid, owner} is loaded on every granted read. The next cycle the owner's rvalid goes to 1 and `rdata` = `mem_dataout`. Writes produce no rvalid.
- **State register `last_win`:** updated to the winner on every grant.
- **`burst_cnt`:**
  - Increments when the same requester wins again.
  - Resets to 1 when the winner changes.
  - Saturates at MAX_BURST.
  - Holds when there is no grant.
- **Round-robin decision (macro defined):**
  - Only one req: that requester wins.
  - Both req and `burst_cnt` < MAX_BURST: `last_win` wins again. Sequential accesses stay together.
  - Both req and `burst_cnt` == MAX_BURST: the other requester wins.
- **Simultaneous first request after reset:** `last_win` resets to B and `burst_cnt` to MAX_BURST, so A wins.
- **Write then read of the same address on consecutive cycles:** the read returns the new value. The memory write completes at the first edge.
- **Read by A then read by B back-to-back:** `a_rvalid` and `b_rvalid` pulse on consecutive cycles. They are never both high.

## Timing
- Grant latency: 0 cycles. gnt is asserted in the same cycle as req when the requester wins.
- Read latency: 1 cycle. The read granted at edge n has `*_rvalid`=1 and valid `rdata` during cycle n+1.
- Throughput: 1 access per cycle, sustained.
- Reset values:
  - `a_gnt`=`b_gnt`=0 while `rst_n`=0.
  - `a_rvalid`=`b_rvalid`=0.
  - `rdata`=0.
  - `mem_write_en`=0.
  - `mem_addr`=0.
  - `mem_datain`=0.
  - `last_win`=B.
  - `burst_cnt`=MAX_BURST.
- Reset asserted mid-operation:
  - A pending read is discarded and no rvalid follows.
  - Outputs go to reset values immediately, without waiting for a clock edge.
  - `mem_write_en` is forced 0 so no write is issued.
- Requesters must hold req/we/addr/wdata stable until gnt. Dropping req before gnt is legal; the request is withdrawn.

## Configuration
- `DMEM_ARB_RR_EN` defined: round-robin with MAX_BURST fairness, as above.
- `DMEM_ARB_RR_EN` not defined: fixed priority.
  - A always wins when `a_req`=1; B is granted only when `a_req`=0.
  - The `burst_cnt` logic is not built.
  - `last_win` is still maintained but does not affect arbitration.

## Test plan
- Reset then single A write of 12'd5 to 8, then A read of 8. Required: `a_gnt`=1 in each request cycle, `mem_write_en`=1 then 0, `a_rvalid`=1 one cycle after the read grant with `rdata`=5, `b_rvalid`=0 throughout.
- Both requesters read continuously, MAX_BURST=4, RR mode. Required: grant sequence A,A,A,A,B,B,B,B,A…, each rvalid one cycle after its grant, owner tags correct.
- Fixed-priority build, both requesters reading continuously for 10 cycles. Required: 10 `a_gnt`, 0 `b_gnt`. `a_req` then drops and `b_gnt`=1 in the same cycle.
- B writes 12'd7 to 516 and A reads 516 in the next cycle. Required: `rdata`=7 with `a_rvalid` high.
- Assert `rst_n`=0 in the cycle after a granted B read. Required: `b_rvalid` stays 0, all outputs at reset values, no memory write, and the next simultaneous request goes to A.
- Idle cycles between accesses: no req. Required: `mem_write_en`=0, `mem_addr` holds the last granted address, no rvalid pulses.
